// File: rtl/wb_pwm_pkg.sv
// Shared definitions for the Wishbone PWM responder.
// Holds the register offsets, CTRL bit positions, the offset-decode width
// and the Wishbone response state encoding used by wb_pwm_slave.
package wb_pwm_pkg;

    // Word offset decode: byte address bits [3:2]
    localparam int unsigned OFFS_W = 2;

    typedef enum logic [OFFS_W-1:0] {
        REG_CTRL   = 2'd0,
        REG_PERIOD = 2'd1,
        REG_DUTY   = 2'd2,
        REG_COUNT  = 2'd3
    } reg_sel_e;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_POL_BIT = 1;
    localparam int unsigned CTRL_W       = 2;

    // Response state: each non-idle state is one cycle of ack or err
    typedef enum logic [1:0] {
        WB_IDLE = 2'b00,
        WB_ACK  = 2'b01,
        WB_ERR  = 2'b10
    } wb_state_e;

endpackage

// File: rtl/wb_pwm_slave_pwm_core.sv
// PWM generator core.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   en_i          channel enable
//   pol_i         output polarity (1 = inverted)
//   period_i      shadow period P
//   duty_i        shadow duty D
//   cnt_o         live counter value
//   pwm_out_o     registered PWM output
//   pwm_wrap_o    high on the cycle the counter equals the active period
module pwm_core #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 pol_i,
    input  logic [CNT_WIDTH-1:0] period_i,
    input  logic [CNT_WIDTH-1:0] duty_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 pwm_out_o,
    output logic                 pwm_wrap_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] p_act_q, p_act_d;
    logic [CNT_WIDTH-1:0] d_act_q, d_act_d;
    logic                 pwm_q, pwm_d;
    logic                 at_end;

    assign at_end = (cnt_q == p_act_q);

    always_comb begin
        cnt_d   = cnt_q;
        p_act_d = p_act_q;
        d_act_d = d_act_q;
        pwm_d   = pol_i;
        if (!en_i) begin
            // Disabled: hold at zero and track the shadow registers so that
            // enabling starts a clean period with the latest settings.
            cnt_d   = '0;
            p_act_d = period_i;
            d_act_d = duty_i;
        end else begin
            pwm_d = (cnt_q < d_act_q) ^ pol_i;
            if (at_end) begin
                cnt_d   = '0;
                p_act_d = period_i;
                d_act_d = duty_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            p_act_q <= '0;
            d_act_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            p_act_q <= p_act_d;
            d_act_q <= d_act_d;
            pwm_q   <= pwm_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign pwm_out_o  = pwm_q;
    assign pwm_wrap_o = en_i & at_end;

endmodule

// File: rtl/wb_pwm_slave.sv
// Wishbone classic responder exposing one PWM channel.
// Register map (byte offsets): 0x00 CTRL (EN, POL), 0x04 PERIOD, 0x08 DUTY,
// 0x0C COUNT (read-only). Unmapped accesses and COUNT writes return err.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   s_wb_*         Wishbone classic slave port (adr, dat_w, dat_r, we, sel,
//                  cyc, stb, ack, err)
//   pwm_out        PWM output
//   pwm_wrap       pulse at each period boundary
module wb_pwm_slave
    import wb_pwm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_wb_adr,
    input  logic [DATA_WIDTH-1:0] s_wb_dat_w,
    output logic [DATA_WIDTH-1:0] s_wb_dat_r,
    input  logic                  s_wb_we,
    input  logic [SEL_WIDTH-1:0]  s_wb_sel,
    input  logic                  s_wb_cyc,
    input  logic                  s_wb_stb,
    output logic                  s_wb_ack,
    output logic                  s_wb_err,
    output logic                  pwm_out,
    output logic                  pwm_wrap
);

    wb_state_e             state_q, state_d;
    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [CNT_WIDTH-1:0]  period_q, period_d;
    logic [CNT_WIDTH-1:0]  duty_q, duty_d;
    logic [DATA_WIDTH-1:0] dat_r_q, dat_r_d;
    logic [CNT_WIDTH-1:0]  cnt;

    reg_sel_e              offs;
    logic                  accept;
    logic                  unmapped;
    logic                  bad;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [DATA_WIDTH-1:0] merged;
    logic                  unused_bits;

    assign offs     = reg_sel_e'(s_wb_adr[3:2]);
    assign unmapped = |s_wb_adr[15:4];
    assign accept   = s_wb_cyc & s_wb_stb & (state_q == WB_IDLE);
    assign bad      = unmapped | (s_wb_we & (offs == REG_COUNT));

    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            wmask[i] = s_wb_sel[i / 8];
        end
    end

    always_comb begin
        rd_val = '0;
        case (offs)
            REG_CTRL:   rd_val = DATA_WIDTH'(ctrl_q);
            REG_PERIOD: rd_val = DATA_WIDTH'(period_q);
            REG_DUTY:   rd_val = DATA_WIDTH'(duty_q);
            REG_COUNT:  rd_val = DATA_WIDTH'(cnt);
            default:    rd_val = '0;
        endcase
    end

    // Byte-merge against the addressed register; truncation on assignment
    // drops any bytes above the field width.
    assign merged = (rd_val & ~wmask) | (s_wb_dat_w & wmask);

    always_comb begin
        state_d  = WB_IDLE;
        ctrl_d   = ctrl_q;
        period_d = period_q;
        duty_d   = duty_q;
        dat_r_d  = '0;
        if (accept) begin
            state_d = bad ? WB_ERR : WB_ACK;
            if (!bad) begin
                if (s_wb_we) begin
                    case (offs)
                        REG_CTRL:   ctrl_d   = merged[CTRL_W-1:0];
                        REG_PERIOD: period_d = merged[CNT_WIDTH-1:0];
                        REG_DUTY:   duty_d   = merged[CNT_WIDTH-1:0];
                        default:    ;
                    endcase
                end else begin
                    dat_r_d = rd_val;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WB_IDLE;
            ctrl_q   <= '0;
            period_q <= '0;
            duty_q   <= '0;
            dat_r_q  <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            dat_r_q  <= dat_r_d;
        end
    end

    assign s_wb_ack   = (state_q == WB_ACK);
    assign s_wb_err   = (state_q == WB_ERR);
    assign s_wb_dat_r = dat_r_q;

    pwm_core #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_core (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (ctrl_q[CTRL_EN_BIT]),
        .pol_i      (ctrl_q[CTRL_POL_BIT]),
        .period_i   (period_q),
        .duty_i     (duty_q),
        .cnt_o      (cnt),
        .pwm_out_o  (pwm_out),
        .pwm_wrap_o (pwm_wrap)
    );

    // Address bits outside the decode, data bytes above the field width and
    // upper merge bits are intentionally ignored.
    assign unused_bits = ^{s_wb_adr, s_wb_dat_w, merged, wmask};

endmodule

// File: tb/tb_wb_pwm_slave.sv
module tb_wb_pwm_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_wb_adr;
    logic [31:0] s_wb_dat_w;
    logic [31:0] s_wb_dat_r;
    logic        s_wb_we;
    logic [3:0]  s_wb_sel;
    logic        s_wb_cyc;
    logic        s_wb_stb;
    logic        s_wb_ack;
    logic        s_wb_err;
    logic        pwm_out;
    logic        pwm_wrap;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          tcyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    wb_pwm_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .SEL_WIDTH  (4),
        .CNT_WIDTH  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_wb_adr   (s_wb_adr),
        .s_wb_dat_w (s_wb_dat_w),
        .s_wb_dat_r (s_wb_dat_r),
        .s_wb_we    (s_wb_we),
        .s_wb_sel   (s_wb_sel),
        .s_wb_cyc   (s_wb_cyc),
        .s_wb_stb   (s_wb_stb),
        .s_wb_ack   (s_wb_ack),
        .s_wb_err   (s_wb_err),
        .pwm_out    (pwm_out),
        .pwm_wrap   (pwm_wrap)
    );

    // Reference waveform: t counts cycles after the enabling write was acked
    // (t=0 is the ack cycle, where the counter sits at 0). The registered
    // output shows the comparison for counter value t-1.
    function automatic logic pwm_ref(input int t, input int p, input int d, input logic pol);
        int c;
        if (t == 0) return pol;
        c = (t - 1) % (p + 1);
        return logic'(c < d) ^ pol;
    endfunction

    // One Wishbone access; returns in the cycle after acceptance.
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output logic ack, output logic err,
                             output logic [31:0] rd);
        @(posedge clk); #1;
        s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = we;
        s_wb_adr = adr; s_wb_dat_w = dat; s_wb_sel = sel;
        @(posedge clk); #1;
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0; s_wb_we = 1'b0;
        ack = s_wb_ack; err = s_wb_err; rd = s_wb_dat_r;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic a, e;
        logic [31:0] d;
        wb_access(1'b1, adr, dat, 4'hF, a, e, d);
    endtask

    task automatic test_reset;
        logic a, e;
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (s_wb_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", s_wb_ack); end
        n_cmp++;
        if (s_wb_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", s_wb_err); end
        n_cmp++;
        if (s_wb_dat_r !== 32'h0) begin n_bad++; $display("FAIL reset_dat: got %h want 0", s_wb_dat_r); end
        n_cmp++;
        if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
        n_cmp++;
        if (pwm_wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", pwm_wrap); end
        n_cmp++;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_access(1'b0, 32'(i * 4), 32'h0, 4'hF, a, e, d);
            if (a !== 1'b1 || e !== 1'b0) begin
                n_bad++; $display("FAIL reset_read_resp[%0d]: got ack=%b err=%b want ack=1 err=0", i, a, e);
            end
            n_cmp++;
            if (d !== 32'h0) begin n_bad++; $display("FAIL reset_read_data[%0d]: got %h want 0", i, d); end
            n_cmp++;
            @(posedge clk); #1;
            if (s_wb_ack !== 1'b0) begin n_bad++; $display("FAIL ack_single[%0d]: got %b want 0", i, s_wb_ack); end
            n_cmp++;
        end
        if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL reset_pwm_idle: got %b want 0", pwm_out); end
        n_cmp++;
    endtask

    task automatic test_basic_pwm;
        int t0, t;
        wr(32'h0, 32'h0);
        wr(32'h4, 32'd9);
        wr(32'h8, 32'd3);
        wr(32'h0, 32'h1);
        t0 = tcyc;
        for (int n = 0; n < 35; n++) begin
            @(posedge clk); #1;
            t = tcyc - t0;
            if (pwm_out !== pwm_ref(t, 9, 3, 1'b0)) begin
                n_bad++; $display("FAIL basic_pwm t=%0d: got %b want %b", t, pwm_out, pwm_ref(t, 9, 3, 1'b0));
            end
            n_cmp++;
            if (pwm_wrap !== logic'((t % 10) == 9)) begin
                n_bad++; $display("FAIL basic_wrap t=%0d: got %b want %b", t, pwm_wrap, (t % 10) == 9);
            end
            n_cmp++;
        end
    endtask

    task automatic test_duty_update;
        int t0, t, c, d;
        logic exp;
        wr(32'h0, 32'h0);
        wr(32'h4, 32'd9);
        wr(32'h8, 32'd3);
        wr(32'h0, 32'h1);
        t0 = tcyc;
        wr(32'h8, 32'd7);   // lands mid first period
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            t = tcyc - t0;
            c = t - 1;
            d = (c / 10 == 0) ? 3 : 7;
            exp = logic'((c % 10) < d);
            if (pwm_out !== exp) begin
                n_bad++; $display("FAIL duty_update t=%0d: got %b want %b", t, pwm_out, exp);
            end
            n_cmp++;
        end
    endtask

    task automatic test_byte_sel;
        logic a, e;
        logic [31:0] d;
        logic [31:0] wdat [4]  = '{32'h1234_ABCD, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 32'hFFFF_FFFC};
        logic [31:0] wadr [4]  = '{32'h4, 32'h4, 32'h8, 32'h0};
        logic [3:0]  wsel [4]  = '{4'b0001, 4'b1110, 4'b1111, 4'b1111};
        logic [31:0] wexp [4]  = '{32'h0000_00CD, 32'h0000_FFCD, 32'h0000_5A5A, 32'h0};
        wr(32'h0, 32'h0);
        wr(32'h4, 32'd0);
        for (int i = 0; i < 4; i++) begin
            wb_access(1'b1, wadr[i], wdat[i], wsel[i], a, e, d);
            wb_access(1'b0, wadr[i], 32'h0, 4'hF, a, e, d);
            if (d !== wexp[i]) begin n_bad++; $display("FAIL byte_sel[%0d]: got %h want %h", i, d, wexp[i]); end
            n_cmp++;
        end
        // CTRL with sel[0] clear must not change
        wb_access(1'b1, 32'h0, 32'hFFFF_FFFF, 4'b1110, a, e, d);
        wb_access(1'b0, 32'h0, 32'h0, 4'hF, a, e, d);
        if (d !== 32'h0) begin n_bad++; $display("FAIL byte_sel_ctrl: got %h want 0", d); end
        n_cmp++;
    endtask

    task automatic test_errors;
        logic a, e;
        logic [31:0] d;
        int t0, tr;
        logic [31:0] eadr [4] = '{32'hC, 32'h10, 32'h14, 32'h8000};
        logic        ewe  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        wr(32'h0, 32'h0);
        wr(32'h4, 32'd9);
        wr(32'h8, 32'd3);
        wr(32'h0, 32'h1);
        t0 = tcyc;
        for (int i = 0; i < 4; i++) begin
            wb_access(ewe[i], eadr[i], 32'h3, 4'hF, a, e, d);
            if (a !== 1'b0 || e !== 1'b1) begin
                n_bad++; $display("FAIL err_resp[%0d]: got ack=%b err=%b want ack=0 err=1", i, a, e);
            end
            n_cmp++;
            if (d !== 32'h0) begin n_bad++; $display("FAIL err_data[%0d]: got %h want 0", i, d); end
            n_cmp++;
            @(posedge clk); #1;
            if (s_wb_err !== 1'b0) begin n_bad++; $display("FAIL err_single[%0d]: got %b want 0", i, s_wb_err); end
            n_cmp++;
        end
        wb_access(1'b0, 32'hC, 32'h0, 4'hF, a, e, d);
        tr = tcyc - t0;
        if (a !== 1'b1 || d !== 32'((tr - 1) % 10)) begin
            n_bad++; $display("FAIL count_live: got ack=%b %h want ack=1 %h", a, d, 32'((tr - 1) % 10));
        end
        n_cmp++;
        if (pwm_out !== pwm_ref(tr, 9, 3, 1'b0)) begin
            n_bad++; $display("FAIL err_pwm_undisturbed: got %b want %b", pwm_out, pwm_ref(tr, 9, 3, 1'b0));
        end
        n_cmp++;
        wb_access(1'b0, 32'h4, 32'h0, 4'hF, a, e, d);
        if (d !== 32'd9) begin n_bad++; $display("FAIL period_after_err: got %h want 9", d); end
        n_cmp++;
    endtask

    task automatic test_edges;
        logic a, e;
        logic [31:0] d;
        int t0, t, dv;
        logic pol, exp;
        for (int k = 0; k < 4; k++) begin
            dv  = (k % 2 == 1) ? 12 : 0;
            pol = logic'(k / 2);
            wr(32'h0, {30'h0, pol, 1'b0});
            wr(32'h4, 32'd9);
            wr(32'h8, 32'(dv));
            wr(32'h0, {30'h0, pol, 1'b1});
            t0 = tcyc;
            exp = logic'(dv != 0) ^ pol;
            for (int n = 0; n < 22; n++) begin
                @(posedge clk); #1;
                t = tcyc - t0;
                if (pwm_out !== exp) begin
                    n_bad++; $display("FAIL edge_const k=%0d t=%0d: got %b want %b", k, t, pwm_out, exp);
                end
                n_cmp++;
            end
        end
        // P=0: wrap every cycle
        wr(32'h0, 32'h0);
        wr(32'h4, 32'd0);
        wr(32'h8, 32'd1);
        wr(32'h0, 32'h1);
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (pwm_wrap !== 1'b1 || pwm_out !== 1'b1) begin
                n_bad++; $display("FAIL p0_wrap n=%0d: got wrap=%b pwm=%b want wrap=1 pwm=1", n, pwm_wrap, pwm_out);
            end
            n_cmp++;
        end
        // Disable: counter cleared, output back to POL (0)
        wr(32'h0, 32'h0);
        @(posedge clk); #1;
        if (pwm_wrap !== 1'b0 || pwm_out !== 1'b0) begin
            n_bad++; $display("FAIL disable: got wrap=%b pwm=%b want 0 0", pwm_wrap, pwm_out);
        end
        n_cmp++;
        wb_access(1'b0, 32'hC, 32'h0, 4'hF, a, e, d);
        if (d !== 32'h0) begin n_bad++; $display("FAIL disable_count: got %h want 0", d); end
        n_cmp++;
    endtask

    task automatic test_reset_mid;
        logic a, e;
        logic [31:0] d;
        wr(32'h4, 32'h55);
        @(posedge clk); #1;
        s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b1;
        s_wb_adr = 32'h8; s_wb_dat_w = 32'h77; s_wb_sel = 4'hF;
        rst = 1'b1;
        @(posedge clk); #1;
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0; s_wb_we = 1'b0;
        rst = 1'b0;
        if (s_wb_ack !== 1'b0 || s_wb_err !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_resp: got ack=%b err=%b want 0 0", s_wb_ack, s_wb_err);
        end
        n_cmp++;
        wb_access(1'b0, 32'h4, 32'h0, 4'hF, a, e, d);
        if (d !== 32'h0) begin n_bad++; $display("FAIL rst_mid_period: got %h want 0", d); end
        n_cmp++;
        wb_access(1'b0, 32'h8, 32'h0, 4'hF, a, e, d);
        if (d !== 32'h0) begin n_bad++; $display("FAIL rst_mid_duty: got %h want 0", d); end
        n_cmp++;
    endtask

    task automatic test_random;
        logic a, e;
        logic [31:0] d;
        int p, dv, t0, t, tr;
        logic pol;
        for (int it = 0; it < 8; it++) begin
            p   = int'($urandom_range(0, 14));
            dv  = int'($urandom_range(0, p + 3));
            pol = logic'($urandom_range(0, 1));
            wr(32'h4, {16'($urandom), 16'(p)});
            wr(32'h8, {16'($urandom), 16'(dv)});
            wb_access(1'b0, 32'h4, 32'h0, 4'hF, a, e, d);
            if (d !== 32'(p)) begin n_bad++; $display("FAIL rand_period_rb it=%0d: got %h want %h", it, d, 32'(p)); end
            n_cmp++;
            wr(32'h0, {30'h0, pol, 1'b0});
            wr(32'h0, {30'h0, pol, 1'b1});
            t0 = tcyc;
            for (int n = 0; n < 2 * (p + 1) + 3; n++) begin
                @(posedge clk); #1;
                t = tcyc - t0;
                if (pwm_out !== pwm_ref(t, p, dv, pol) || pwm_wrap !== logic'((t % (p + 1)) == p)) begin
                    n_bad++;
                    $display("FAIL rand_pwm it=%0d P=%0d D=%0d pol=%b t=%0d: got pwm=%b wrap=%b want pwm=%b wrap=%b",
                             it, p, dv, pol, t, pwm_out, pwm_wrap, pwm_ref(t, p, dv, pol), (t % (p + 1)) == p);
                end
                n_cmp++;
            end
            wb_access(1'b0, 32'hC, 32'h0, 4'hF, a, e, d);
            tr = tcyc - t0;
            if (d !== 32'((tr - 1) % (p + 1))) begin
                n_bad++; $display("FAIL rand_count it=%0d: got %h want %h", it, d, 32'((tr - 1) % (p + 1)));
            end
            n_cmp++;
            wr(32'h0, {30'h0, pol, 1'b0});
        end
    endtask

    initial begin
        rst = 1'b1;
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0; s_wb_we = 1'b0;
        s_wb_adr = '0; s_wb_dat_w = '0; s_wb_sel = '0;
        test_reset;
        test_basic_pwm;
        test_duty_update;
        test_byte_sel;
        test_errors;
        test_edges;
        test_random;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
